// File: rtl/hex_frame_serializer.sv
// Frame-to-ASCII-hex serializer for the UART TX byte path: CHANNELS samples in, "HHHH,HHHH,...\r\n" out.
// Define HEXSER_SEQ_EN to prefix each frame with an 8-bit frame counter as "NN:".
module hex_frame_serializer #(
    parameter int          CHANNELS    = 3,
    parameter int          HEX_DIGIT_W = 4,
    parameter int          BINARY_W    = HEX_DIGIT_W * 4,
    parameter logic [7:0]  SEP_CHAR    = 8'h2C
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*BINARY_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_data,
    output logic                         busy
);
    localparam int FW = CHANNELS * BINARY_W;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW = (HEX_DIGIT_W > 1) ? $clog2(HEX_DIGIT_W) : 1;
    localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
    localparam logic [DW-1:0] DG_LAST = DW'(HEX_DIGIT_W - 1);

    typedef enum logic [2:0] {
        IDLE, DIGIT, SEP, CR, LF
`ifdef HEXSER_SEQ_EN
        , SEQ_HI, SEQ_LO, COLON
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   chan_q, chan_d;
    logic [DW-1:0]   digit_q, digit_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            in_ready_q, in_ready_d;
    logic [FW-1:0]   nib_sh;
    logic            xfer;
`ifdef HEXSER_SEQ_EN
    logic [7:0]      seq_q, seq_d;
`endif

    // 'A'-10 == 8'h37, so letters are 8'h37 + n
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign xfer = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        digit_d     = digit_q;
        frame_d     = frame_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
`ifdef HEXSER_SEQ_EN
        seq_d       = seq_q;
`endif
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                frame_d     = in_data;
                chan_d      = '0;
                digit_d     = DG_LAST;
                out_valid_d = 1'b1;
                in_ready_d  = 1'b0;
`ifdef HEXSER_SEQ_EN
                state_d     = SEQ_HI;
`else
                state_d     = DIGIT;
`endif
            end
            DIGIT: if (xfer) begin
                if (digit_q != '0)          digit_d = digit_q - DW'(1);
                else if (chan_q != CH_LAST) state_d = SEP;
                else                        state_d = CR;
            end
            SEP: if (xfer) begin
                chan_d  = chan_q + CW'(1);
                digit_d = DG_LAST;
                state_d = DIGIT;
            end
            CR: if (xfer) state_d = LF;
            LF: if (xfer) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
`ifdef HEXSER_SEQ_EN
                seq_d       = seq_q + 8'd1;
`endif
            end
`ifdef HEXSER_SEQ_EN
            SEQ_HI: if (xfer) state_d = SEQ_LO;
            SEQ_LO: if (xfer) state_d = COLON;
            COLON:  if (xfer) state_d = DIGIT;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Byte is derived from the next state, so it is registered and naturally stable during stalls.
    always_comb begin
        nib_sh = frame_d >> (int'(chan_d) * BINARY_W + int'(digit_d) * 4);
        case (state_d)
            DIGIT:   out_data_d = hex_char(nib_sh[3:0]);
            SEP:     out_data_d = SEP_CHAR;
            CR:      out_data_d = 8'h0D;
            LF:      out_data_d = 8'h0A;
`ifdef HEXSER_SEQ_EN
            SEQ_HI:  out_data_d = hex_char(seq_q[7:4]);
            SEQ_LO:  out_data_d = hex_char(seq_q[3:0]);
            COLON:   out_data_d = 8'h3A;
`endif
            default: out_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            chan_q      <= '0;
            digit_q     <= '0;
            frame_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            in_ready_q  <= 1'b1;
`ifdef HEXSER_SEQ_EN
            seq_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            digit_q     <= digit_d;
            frame_q     <= frame_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
`ifdef HEXSER_SEQ_EN
            seq_q       <= seq_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = !in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_hex_frame_serializer.sv
// Bench for hex_frame_serializer: directed tables, random frames vs a string-level model, reset and b2b sequences.
module tb_hex_frame_serializer;
    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [47:0] in_data;
    logic [7:0]  out_data;
    logic        in_valid_b, in_ready_b, out_valid_b, busy_b;
    logic [7:0]  in_data_b, out_data_b;

`ifdef HEXSER_SEQ_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    hex_frame_serializer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

    hex_frame_serializer #(.CHANNELS(1), .HEX_DIGIT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(1'b1), .out_data(out_data_b), .busy(busy_b));

    initial begin clk = 1'b0; forever #5 clk = ~clk; end

    int n_chk = 0, n_pass = 0;
    int duty = 100;
    int cyc = 0, lf_cyc = 0;
    int fa_cnt = 0, fb_cnt = 0;
    byte unsigned rxq[$];
    byte unsigned exp_b[0:63];
    int exp_n;

    function automatic void chk(input bit ok, input string nm, input longint act, input longint expv);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endfunction

    function automatic byte unsigned hexc(input int n);
        return (n < 10) ? byte'(48 + n) : byte'(55 + n);
    endfunction

    function automatic void push_e(input byte unsigned b);
        exp_b[exp_n] = b;
        exp_n++;
    endfunction

    function automatic void prefix(input int seq);
        exp_n = 0;
        if (SEQ_EN) begin
            push_e(hexc((seq / 16) % 16));
            push_e(hexc(seq % 16));
            push_e(8'h3A);
        end
    endfunction

    // Reference: each channel printed as hd hex digits, MSB first, comma-joined, CR LF terminated.
    function automatic void model(input logic [47:0] d, input int ch, input int hd, input int seq);
        prefix(seq);
        for (int k = 0; k < ch; k++) begin
            if (k > 0) push_e(8'h2C);
            for (int dg = hd - 1; dg >= 0; dg--)
                push_e(hexc(int'((d >> (k * hd * 4 + dg * 4)) & 48'hF)));
        end
        push_e(8'h0D);
        push_e(8'h0A);
    endfunction

    function automatic void from_str(input string s, input int seq);
        prefix(seq);
        for (int i = 0; i < s.len(); i++) push_e(s[i]);
        push_e(8'h0D);
        push_e(8'h0A);
    endfunction

    // Protocol monitor: byte capture, stall hold, first-byte latency, in_ready/busy phase
    bit          inflight = 0, stall = 0, first_pend = 0;
    logic [7:0]  stall_data = 8'h00;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            inflight = 0; stall = 0; first_pend = 0;
        end else begin
            chk(in_ready == !inflight, "in_ready_phase", in_ready, !inflight);
            chk(busy == !in_ready, "busy_vs_ready", busy, !in_ready);
            if (first_pend) chk(out_valid == 1'b1, "first_byte_latency", out_valid, 1);
            first_pend = 0;
            if (stall) chk(out_valid && out_data == stall_data, "stall_hold", {out_valid, out_data}, {1'b1, stall_data});
            stall = out_valid && !out_ready;
            stall_data = out_data;
            if (out_valid && out_ready) begin
                rxq.push_back(out_data);
                if (out_data == 8'h0A) begin inflight = 0; lf_cyc = cyc; end
            end
            if (in_valid && in_ready) begin inflight = 1; first_pend = 1; end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 99) < duty);
        end
    end

    task automatic wait_accept_a();
        int n = 0;
        forever begin
            @(negedge clk);
            if (in_valid && in_ready) break;
            n++;
            if (n > 3000) begin chk(1'b0, "accept_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_a(input logic [47:0] d);
        @(posedge clk); #1;
        in_data = d; in_valid = 1'b1;
        wait_accept_a();
        in_valid = 1'b0;
    endtask

    task automatic check_frame_a(input string nm);
        int n = 0;
        bit ok = 1;
        int bad = 0;
        byte unsigned g, gb = 0, eb = 0;
        while (rxq.size() < exp_n && n < 3000) begin @(negedge clk); n++; end
        if (rxq.size() < exp_n) begin
            chk(1'b0, {nm, "_timeout"}, rxq.size(), exp_n);
            rxq.delete();
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                g = rxq.pop_front();
                if (ok && g != exp_b[i]) begin ok = 0; bad = i; gb = g; eb = exp_b[i]; end
            end
            chk(ok, $sformatf("%s_byte%0d", nm, bad), gb, eb);
        end
        fa_cnt = (fa_cnt + 1) % 256;
    endtask

    task automatic run_b(input logic [7:0] d, input string s);
        int n = 0;
        @(posedge clk); #1;
        in_data_b = d; in_valid_b = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready_b) break;
            n++;
            if (n > 100) begin chk(1'b0, "b_accept_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        from_str(s, fb_cnt);
        for (int i = 0; i < exp_n; i++) begin
            @(negedge clk);
            chk(out_valid_b && out_data_b == exp_b[i], $sformatf("b_%s_byte%0d", s, i),
                {out_valid_b, out_data_b}, {1'b1, exp_b[i]});
        end
        @(negedge clk);
        chk(!out_valid_b && in_ready_b && !busy_b, "b_idle_after_lf", {out_valid_b, in_ready_b, busy_b}, 3'b010);
        fb_cnt = (fb_cnt + 1) % 256;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        rxq.delete(); fa_cnt = 0; fb_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    typedef struct { logic [47:0] data; int duty; string exp; } vec_t;
    typedef struct { logic [7:0] data; string exp; } vecb_t;
    vec_t  tv[5];
    vecb_t tvb[3];

    initial begin
        logic [47:0] rd;
        tv[0] = '{48'hF00F_ABCD_1234, 100, "1234,ABCD,F00F"};
        tv[1] = '{48'hF00F_ABCD_1234,  30, "1234,ABCD,F00F"};
        tv[2] = '{48'hFFFF_0000_8001,  60, "8001,0000,FFFF"};
        tv[3] = '{48'h0000_0009_000A, 100, "000A,0009,0000"};
        tv[4] = '{48'h89AB_CDEF_0123,  50, "0123,CDEF,89AB"};
        tvb[0] = '{8'h7E, "7E"};
        tvb[1] = '{8'hC3, "C3"};
        tvb[2] = '{8'h05, "05"};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_valid_b = 1'b0; in_data_b = '0;
        #12;
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(out_data == 8'h00, "rst_out_data", out_data, 0);
        do_reset();

        for (int i = 0; i < 5; i++) begin
            duty = tv[i].duty;
            send_a(tv[i].data);
            from_str(tv[i].exp, fa_cnt);
            check_frame_a($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 3; i++) run_b(tvb[i].data, tvb[i].exp);

        for (int i = 0; i < 12; i++) begin
            duty = $urandom_range(20, 100);
            rd = {16'($urandom), 32'($urandom)};
            send_a(rd);
            model(rd, 3, 4, fa_cnt);
            check_frame_a($sformatf("rand%0d", i));
        end

        // Back-to-back with in_valid held; in_data changes while the second frame is busy
        duty = 100;
        @(posedge clk); #1;
        in_data = 48'h1111_2222_3333; in_valid = 1'b1;
        wait_accept_a();
        in_data = 48'hBEEF_0042_CAFE;
        wait_accept_a();
        chk(cyc - lf_cyc == 1, "b2b_gap", cyc - lf_cyc, 1);
        in_data = 48'h5555_6666_7777;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        model(48'h1111_2222_3333, 3, 4, fa_cnt);
        check_frame_a("b2b_first");
        from_str("CAFE,0042,BEEF", fa_cnt);
        check_frame_a("b2b_second");
        repeat (4) @(negedge clk);
        chk(rxq.size() == 0 && in_ready, "b2b_no_extra", rxq.size(), 0);

        // Reset mid-frame discards the partial frame
        send_a(48'hF00F_ABCD_1234);
        begin
            int n = 0;
            while (rxq.size() < 5 && n < 200) begin @(negedge clk); n++; end
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk(out_valid == 1'b0, "midrst_out_valid", out_valid, 0);
        chk(in_ready == 1'b1, "midrst_in_ready", in_ready, 1);
        chk(busy == 1'b0, "midrst_busy", busy, 0);
        chk(out_data == 8'h00, "midrst_out_data", out_data, 0);
        rxq.delete(); fa_cnt = 0; fb_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_a(48'h0000_0009_000A);
        from_str("000A,0009,0000", fa_cnt);
        check_frame_a("post_reset");

        // 257 frames: frame counter wraps when the prefix is enabled
        do_reset();
        duty = 100;
        for (int f = 0; f < 257; f++) begin
            send_a(48'h0001_0001_0001);
            from_str("0001,0001,0001", fa_cnt);
            check_frame_a($sformatf("seq%0d", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
